// File: rtl/stage_w_writeback_if.sv
// ---------------------------------------------------------------------------
// stage_w_writeback_if
//   Bundle between the M/W pipeline register and its neighbours.
//   M-side fields are produced by the memory stage (master). W-side fields
//   are produced by the writeback stage (slave). The W-side fields feed the
//   GRF write port, the GRF write log and the W-level forwarding mux.
//
//   M side : valid_M, PC_M, A3_M, RFWD_Sel_M, ALUOut_M, DMRD_M, LoadType_M
//   W side : A3_W, RFWD_W, PC_W, RegWrite_W, valid_W, retire_cnt[CNT_W]
// ---------------------------------------------------------------------------
interface stage_w_writeback_if #(
    parameter int CNT_W = 32
);
    // M stage -> W stage
    logic             valid_M;
    logic [31:0]      PC_M;
    logic [4:0]       A3_M;
    logic [1:0]       RFWD_Sel_M;
    logic [31:0]      ALUOut_M;
    logic [31:0]      DMRD_M;
    logic [2:0]       LoadType_M;

    // W stage -> GRF / forwarding / trace
    logic [4:0]       A3_W;
    logic [31:0]      RFWD_W;
    logic [31:0]      PC_W;
    logic             RegWrite_W;
    logic             valid_W;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output valid_M, PC_M, A3_M, RFWD_Sel_M, ALUOut_M, DMRD_M, LoadType_M,
        input  A3_W, RFWD_W, PC_W, RegWrite_W, valid_W, retire_cnt
    );

    modport slave (
        input  valid_M, PC_M, A3_M, RFWD_Sel_M, ALUOut_M, DMRD_M, LoadType_M,
        output A3_W, RFWD_W, PC_W, RegWrite_W, valid_W, retire_cnt
    );
endinterface

// File: rtl/stage_w_writeback.sv
// ---------------------------------------------------------------------------
// stage_w_writeback
//   Writeback stage of the 5-stage MIPS pipeline.
//   - Holds the M/W pipeline register (never stalls, 1-cycle latency).
//   - Extends load data from the raw aligned DM word.
//   - Selects the GRF write value (ALU result, load data, or PC+8 for links).
//   - Counts retired instructions for trace cross-checking.
//
// Ports
//   clk    : system clock, all state on posedge
//   reset  : synchronous, active-high
//   wb     : stage_w_writeback_if.slave (M fields in, W fields out)
//
// Parameters
//   RESET_PC : PC_W after reset (IM base)
//   CNT_W    : retired-instruction counter width
//
// Every output is derived from W registers only, so there is no path from
// the M inputs to any output.
// ---------------------------------------------------------------------------
module stage_w_writeback #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    stage_w_writeback_if.slave   wb
);

    // Write-source select encoding
    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    // Load-type encoding; anything unlisted behaves as lw
    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LBU = 3'b001;
    localparam logic [2:0] LT_LB  = 3'b010;
    localparam logic [2:0] LT_LHU = 3'b011;
    localparam logic [2:0] LT_LH  = 3'b100;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // -----------------------------------------------------------------------
    // M/W pipeline register
    // -----------------------------------------------------------------------
    logic             valid_w_q;
    logic [4:0]       a3_w_q;
    logic [31:0]      pc_w_q;
    logic [1:0]       sel_w_q;
    logic [31:0]      alu_w_q;
    logic [31:0]      dmrd_w_q;
    logic [2:0]       ldtype_w_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Reset wins over capture: the in-flight instruction is dropped
            // and not counted.
            valid_w_q  <= 1'b0;
            a3_w_q     <= 5'd0;
            pc_w_q     <= RESET_PC;
            sel_w_q    <= SEL_ALU;
            alu_w_q    <= 32'd0;
            dmrd_w_q   <= 32'd0;
            ldtype_w_q <= LT_LW;
            cnt_q      <= '0;
        end else begin
            valid_w_q  <= wb.valid_M;
            // A bubble must never look like a write, so its destination is
            // forced to $0; the remaining fields are captured regardless.
            a3_w_q     <= wb.valid_M ? wb.A3_M : 5'd0;
            pc_w_q     <= wb.PC_M;
            sel_w_q    <= wb.RFWD_Sel_M;
            alu_w_q    <= wb.ALUOut_M;
            dmrd_w_q   <= wb.DMRD_M;
            ldtype_w_q <= wb.LoadType_M;
            // Free-running wrap, no saturation.
            if (wb.valid_M)
                cnt_q <= cnt_q + CNT_ONE;
        end
    end

    // -----------------------------------------------------------------------
    // Load extension
    //   Byte lane picked by the full 2-bit offset; halfword lane by off[1]
    //   only (misaligned halfwords are not trapped here).
    // -----------------------------------------------------------------------
    function automatic logic [31:0] load_ext(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [2:0]  ltype
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (ltype)
            LT_LBU:  r = {24'd0, b};
            LT_LB:   r = {{24{b[7]}}, b};
            LT_LHU:  r = {16'd0, h};
            LT_LH:   r = {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Write-value select (combinational from W registers)
    // -----------------------------------------------------------------------
    logic [31:0] rfwd;

    always_comb begin
        rfwd = alu_w_q;
        case (sel_w_q)
            SEL_LOAD: rfwd = load_ext(dmrd_w_q, alu_w_q[1:0], ldtype_w_q);
            SEL_LINK: rfwd = pc_w_q + 32'd8;   // link address, wraps at 2^32
            default:  rfwd = alu_w_q;          // 00 and reserved 11
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign wb.valid_W    = valid_w_q;
    assign wb.A3_W       = a3_w_q;
    assign wb.PC_W       = pc_w_q;
    assign wb.RFWD_W     = rfwd;
    // Writes to $0 are suppressed here; the value is still computed so the
    // forwarding path sees a consistent RFWD_W.
    assign wb.RegWrite_W = valid_w_q && (a3_w_q != 5'd0);
    assign wb.retire_cnt = cnt_q;

endmodule

// File: tb/tb_stage_w_writeback.sv
// ---------------------------------------------------------------------------
// tb_stage_w_writeback
//   Directed checks of the documented cases plus a randomized run compared
//   against a behavioural model of the writeback rules. Counter width is 4
//   so wrap-around is reached quickly.
// ---------------------------------------------------------------------------
module tb_stage_w_writeback;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    stage_w_writeback_if #(.CNT_W(CNT_W)) wb ();

    stage_w_writeback #(
        .RESET_PC (32'h0000_3000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    logic        exp_valid;
    logic [4:0]  exp_a3;
    logic [31:0] exp_pc;
    logic [31:0] exp_rfwd;
    int          exp_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference write value from the ISA-level meaning of each source.
    function automatic logic [31:0] ref_val(input logic [1:0] sel, input logic [31:0] alu,
                                            input logic [31:0] dmrd, input logic [2:0] lt,
                                            input logic [31:0] pc);
        int unsigned off, byte_v, half_v;
        logic [31:0] r;
        if (sel == 2'b10) return pc + 32'd8;
        if (sel != 2'b01) return alu;
        off    = alu % 4;
        byte_v = (dmrd >> (off * 8)) % 256;
        half_v = (dmrd >> ((off / 2) * 16)) % 65536;
        case (lt)
            3'd1: r = byte_v;
            3'd2: r = (byte_v >= 128) ? byte_v + 32'hFFFF_FF00 : byte_v;
            3'd3: r = half_v;
            3'd4: r = (half_v >= 32768) ? half_v + 32'hFFFF_0000 : half_v;
            default: r = dmrd;
        endcase
        return r;
    endfunction

    // One clock: drive at negedge, update model, check all outputs after edge.
    task automatic step(input string tag, input logic rst, input logic v,
                        input logic [31:0] pc, input logic [4:0] a3, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] dmrd, input logic [2:0] lt);
        @(negedge clk);
        reset         = rst;
        wb.valid_M    = v;
        wb.PC_M       = pc;
        wb.A3_M       = a3;
        wb.RFWD_Sel_M = sel;
        wb.ALUOut_M   = alu;
        wb.DMRD_M     = dmrd;
        wb.LoadType_M = lt;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_valid = 1'b0;
            exp_a3    = 5'd0;
            exp_pc    = 32'h0000_3000;
            exp_rfwd  = 32'd0;
            exp_cnt   = 0;
        end else begin
            exp_valid = v;
            exp_a3    = v ? a3 : 5'd0;
            exp_pc    = pc;
            exp_rfwd  = ref_val(sel, alu, dmrd, lt, pc);
            if (v) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        end
        chk({tag, ".valid"}, {31'd0, wb.valid_W},    {31'd0, exp_valid});
        chk({tag, ".a3"},    {27'd0, wb.A3_W},       {27'd0, exp_a3});
        chk({tag, ".pc"},    wb.PC_W,                exp_pc);
        chk({tag, ".rfwd"},  wb.RFWD_W,              exp_rfwd);
        chk({tag, ".rw"},    {31'd0, wb.RegWrite_W}, {31'd0, exp_valid && exp_a3 != 5'd0});
        chk({tag, ".cnt"},   32'(wb.retire_cnt),     exp_cnt);
    endtask

    initial begin
        reset         = 1'b1;
        wb.valid_M    = 1'b1;
        wb.PC_M       = 32'h0000_4000;
        wb.A3_M       = 5'd9;
        wb.RFWD_Sel_M = 2'b00;
        wb.ALUOut_M   = 32'hDEAD_BEEF;
        wb.DMRD_M     = 32'd0;
        wb.LoadType_M = 3'd0;
        exp_valid = 1'b0; exp_a3 = 5'd0; exp_pc = 32'h3000; exp_rfwd = 32'd0; exp_cnt = 0;

        // 1. Reset with valid_M held high
        step("rst", 1'b1, 1'b1, 32'h4000, 5'd9, 2'b00, 32'hDEAD_BEEF, 32'd0, 3'd0);
        chk("rst.pc_const", wb.PC_W, 32'h0000_3000);
        chk("rst.cnt_const", 32'(wb.retire_cnt), 32'd0);

        // 2. ALU write
        step("alu", 1'b0, 1'b1, 32'h3004, 5'd8, 2'b00, 32'h1234_5678, 32'd0, 3'd0);
        chk("alu.rfwd_const", wb.RFWD_W, 32'h1234_5678);
        chk("alu.cnt_const", 32'(wb.retire_cnt), 32'd1);

        // 3. Loads from 80FF_7F01
        step("lb3",  1'b0, 1'b1, 32'h3008, 5'd2, 2'b01, 32'h0000_1003, 32'h80FF_7F01, 3'd2);
        chk("lb3.const", wb.RFWD_W, 32'hFFFF_FF80);
        step("lbu3", 1'b0, 1'b1, 32'h300C, 5'd2, 2'b01, 32'h0000_1003, 32'h80FF_7F01, 3'd1);
        chk("lbu3.const", wb.RFWD_W, 32'h0000_0080);
        step("lh2",  1'b0, 1'b1, 32'h3010, 5'd2, 2'b01, 32'h0000_1002, 32'h80FF_7F01, 3'd4);
        chk("lh2.const", wb.RFWD_W, 32'hFFFF_80FF);
        step("lhu0", 1'b0, 1'b1, 32'h3014, 5'd2, 2'b01, 32'h0000_1000, 32'h80FF_7F01, 3'd3);
        chk("lhu0.const", wb.RFWD_W, 32'h0000_7F01);
        step("lb1",  1'b0, 1'b1, 32'h3018, 5'd2, 2'b01, 32'h0000_1001, 32'h80FF_7F01, 3'd2);
        chk("lb1.const", wb.RFWD_W, 32'h0000_007F);
        step("lw",   1'b0, 1'b1, 32'h301C, 5'd2, 2'b01, 32'h0000_1000, 32'h80FF_7F01, 3'd0);
        chk("lw.const", wb.RFWD_W, 32'h80FF_7F01);

        // 4. jal link value, including 32-bit wrap
        step("jal", 1'b0, 1'b1, 32'h3010, 5'd31, 2'b10, 32'h0, 32'h0, 3'd0);
        chk("jal.const", wb.RFWD_W, 32'h0000_3018);
        step("jalw", 1'b0, 1'b1, 32'hFFFF_FFFC, 5'd31, 2'b10, 32'h0, 32'h0, 3'd0);
        chk("jalw.const", wb.RFWD_W, 32'h0000_0004);

        // 5. Bubble, then write to $0
        step("bub", 1'b0, 1'b0, 32'h3020, 5'd5, 2'b00, 32'h55, 32'h0, 3'd0);
        chk("bub.a3_const", {27'd0, wb.A3_W}, 32'd0);
        step("zero", 1'b0, 1'b1, 32'h3024, 5'd0, 2'b00, 32'h66, 32'h0, 3'd0);
        chk("zero.rw_const", {31'd0, wb.RegWrite_W}, 32'd0);

        // 6. Counter wrap after 16 captures, then reset on the 17th
        step("wrst", 1'b1, 1'b0, 32'h0, 5'd0, 2'b00, 32'h0, 32'h0, 3'd0);
        for (int i = 0; i < 16; i++)
            step("wrap", 1'b0, 1'b1, 32'h3000 + 32'(4 * i), 5'd3, 2'b00, 32'(i), 32'h0, 3'd0);
        chk("wrap.cnt_const", 32'(wb.retire_cnt), 32'd0);
        step("w17", 1'b1, 1'b1, 32'h3040, 5'd3, 2'b00, 32'h1, 32'h0, 3'd0);
        chk("w17.valid_const", {31'd0, wb.valid_W}, 32'd0);

        // Randomized run with occasional mid-stream reset
        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom,
                 5'($urandom_range(0, 31)),
                 2'($urandom_range(0, 3)),
                 $urandom,
                 $urandom,
                 3'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
